// File: rtl/fan_sample_sched_if.sv
// fan_sample_sched_if: ADC conversion handshake between the sample scheduler and the external ADC.
interface fan_sample_sched_if #(
  parameter int ADC_BITWIDTH = 8
);
  logic                    adcStart_o;
  logic [ADC_BITWIDTH-1:0] adcData_i;
  logic                    adcDone_i;
  modport master (output adcStart_o, input adcData_i, adcDone_i);
  modport slave  (input adcStart_o, output adcData_i, adcDone_i);
endinterface

// File: rtl/fan_sample_sched.sv
// fan_sample_sched: periodic ADC conversion scheduler with overrun/timeout checking and PWM clock-enable divider.
module fan_sample_sched #(
  parameter int ADC_BITWIDTH     = 8,
  parameter int PERIOD_BITWIDTH  = 16,
  parameter int PWM_DIV_BITWIDTH = 8,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        enable_i,
  input  logic [PERIOD_BITWIDTH-1:0]  samplePeriod_i,
  input  logic [PWM_DIV_BITWIDTH-1:0] pwmDivider_i,
  input  logic                        clearErr_i,
  fan_sample_sched_if.master          adc,
  output logic [ADC_BITWIDTH-1:0]     ADC_value_o,
  output logic                        dataValid_STRB_o,
  output logic                        clk_en_PWM_o,
  output logic                        overrun_o,
  output logic                        timeoutErr_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, WAIT_TICK, CONVERT} state_e;
  state_e                      state_q, state_d;
  logic [PERIOD_BITWIDTH-1:0]  cnt_q, cnt_d, per_q, per_d, p_in;
  logic [TW-1:0]               tmo_q, tmo_d;
  logic [PWM_DIV_BITWIDTH-1:0] pwm_q, pwm_d;
  logic [ADC_BITWIDTH-1:0]     adc_value_q, adc_value_d;
  logic adc_start_q, adc_start_d, data_valid_q, data_valid_d, clk_en_pwm_q, clk_en_pwm_d;
  logic overrun_q, overrun_d, timeout_err_q, timeout_err_d;
  logic run, tick, in_conv, done, tmo_hit, pwm_wrap;
  always_comb begin
    p_in          = (samplePeriod_i < PERIOD_BITWIDTH'(2)) ? PERIOD_BITWIDTH'(2) : samplePeriod_i;
    run           = state_q != IDLE;
    tick          = run && (cnt_q == per_q - 1'b1);
    in_conv       = state_q == CONVERT;
    done          = in_conv && adc.adcDone_i;
    tmo_hit       = in_conv && (tmo_q == TW'(TIMEOUT_CYCLES));
    pwm_wrap      = pwm_q >= pwmDivider_i;
    state_d       = !enable_i ? IDLE :
                    (state_q == IDLE) ? WAIT_TICK :
                    (state_q == WAIT_TICK) ? (tick ? CONVERT : WAIT_TICK) :
                    ((done || tmo_hit) ? WAIT_TICK : CONVERT);
    cnt_d         = (!enable_i || !run || tick) ? '0 : cnt_q + 1'b1;
    // period is re-latched only at enable and at wrap so mid-period changes wait a period
    per_d         = (!run || tick) ? p_in : per_q;
    tmo_d         = (enable_i && in_conv) ? tmo_q + 1'b1 : '0;
    adc_start_d   = enable_i && (state_q == WAIT_TICK) && tick;
    data_valid_d  = enable_i && done;
    adc_value_d   = data_valid_d ? adc.adcData_i : adc_value_q;
    overrun_d     = (enable_i && in_conv && tick) || (overrun_q && !clearErr_i);
    timeout_err_d = (enable_i && tmo_hit && !done) || (timeout_err_q && !clearErr_i);
    pwm_d         = (!enable_i || pwm_wrap) ? '0 : pwm_q + 1'b1;
    clk_en_pwm_d  = enable_i && pwm_wrap;
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      per_q         <= '0;
      tmo_q         <= '0;
      pwm_q         <= '0;
      adc_value_q   <= '0;
      adc_start_q   <= 1'b0;
      data_valid_q  <= 1'b0;
      clk_en_pwm_q  <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      per_q         <= per_d;
      tmo_q         <= tmo_d;
      pwm_q         <= pwm_d;
      adc_value_q   <= adc_value_d;
      adc_start_q   <= adc_start_d;
      data_valid_q  <= data_valid_d;
      clk_en_pwm_q  <= clk_en_pwm_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  assign adc.adcStart_o      = adc_start_q;
  assign ADC_value_o         = adc_value_q;
  assign dataValid_STRB_o    = data_valid_q;
  assign clk_en_PWM_o        = clk_en_pwm_q;
  assign overrun_o           = overrun_q;
  assign timeoutErr_o        = timeout_err_q;
endmodule

// File: tb/tb_fan_sample_sched.sv
// tb_fan_sample_sched: directed scenario tasks for fan_sample_sched with a latency-programmable ADC model.
module tb_fan_sample_sched;
  logic clk = 1'b0;
  logic rstn_i, enable_i, clearErr_i;
  logic [15:0] samplePeriod_i;
  logic [7:0]  pwmDivider_i;
  logic [7:0]  ADC_value_o;
  logic dataValid_STRB_o, clk_en_PWM_o, overrun_o, timeoutErr_o;
  logic adc_done = 1'b0;
  logic [7:0] adc_dat = 8'h00;
  int errors = 0, checks = 0;
  int cyc = 0, due = -1, force_cyc = -1, adc_lat = -1, pend = 0, bad_seq = 0;
  logic [7:0] adc_data = 8'h00, force_data = 8'h00;
  int start_q[$], strobe_q[$], pwm_cyc[$];

  fan_sample_sched_if #(.ADC_BITWIDTH(8)) adc_if ();
  assign adc_if.adcDone_i = adc_done;
  assign adc_if.adcData_i = adc_dat;

  fan_sample_sched dut (
    .clk_i(clk), .rstn_i(rstn_i), .enable_i(enable_i), .samplePeriod_i(samplePeriod_i),
    .pwmDivider_i(pwmDivider_i), .clearErr_i(clearErr_i), .adc(adc_if),
    .ADC_value_o(ADC_value_o), .dataValid_STRB_o(dataValid_STRB_o), .clk_en_PWM_o(clk_en_PWM_o),
    .overrun_o(overrun_o), .timeoutErr_o(timeoutErr_o)
  );

  always #5 clk = ~clk;

  // cycle counter, event log and ADC model; done driven here is sampled at the end of this cycle
  always begin
    @(posedge clk);
    #2;
    cyc++;
    if (adc_if.adcStart_o) begin
      start_q.push_back(cyc);
      pend++;
      if (adc_lat >= 0) due = cyc + adc_lat;
    end
    if (dataValid_STRB_o) begin
      strobe_q.push_back(cyc);
      if (pend != 1) bad_seq++;
      pend = 0;
    end
    if (clk_en_PWM_o) pwm_cyc.push_back(cyc);
    adc_done = (cyc == due) || (cyc == force_cyc);
    adc_dat  = (cyc == force_cyc) ? force_data : (cyc == due) ? adc_data : 8'h00;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic setup(input int p, input int lat, input logic [7:0] d, input logic [7:0] div, output int e);
    enable_i = 1'b0;
    clearErr_i = 1'b0;
    repeat (2) @(negedge clk);
    samplePeriod_i = 16'(p);
    pwmDivider_i = div;
    adc_lat = lat;
    adc_data = d;
    due = -1;
    force_cyc = -1;
    pend = 0;
    bad_seq = 0;
    start_q.delete();
    strobe_q.delete();
    pwm_cyc.delete();
    enable_i = 1'b1;
    e = cyc;
  endtask

  task automatic test_reset;
    rstn_i = 1'b0;
    enable_i = 1'b0;
    clearErr_i = 1'b0;
    samplePeriod_i = 16'd10;
    pwmDivider_i = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({adc_if.adcStart_o, ADC_value_o, dataValid_STRB_o, clk_en_PWM_o, overrun_o, timeoutErr_o} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got start=%b val=%h strb=%b pwm=%b ovr=%b tmo=%b expected all 0",
               adc_if.adcStart_o, ADC_value_o, dataValid_STRB_o, clk_en_PWM_o, overrun_o, timeoutErr_o);
    end
    rstn_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({adc_if.adcStart_o, dataValid_STRB_o, clk_en_PWM_o} !== 3'b000) begin
      errors++;
      $display("FAIL idle_disabled: got pulses %b expected 000", {adc_if.adcStart_o, dataValid_STRB_o, clk_en_PWM_o});
    end
  endtask

  task automatic test_nominal;
    int e, bad, first;
    setup(10, 3, 8'h64, 8'd0, e);
    repeat (45) @(negedge clk);
    first = start_q.size() > 0 ? start_q[0] : -1;
    checks++;
    if (start_q.size() != 4 || strobe_q.size() != 4) begin
      errors++;
      $display("FAIL nominal_counts: got starts=%0d strobes=%0d expected 4 and 4", start_q.size(), strobe_q.size());
    end
    checks++;
    if (first != e + 11) begin
      errors++;
      $display("FAIL nominal_first_start: got cycle %0d expected %0d", first, e + 11);
    end
    bad = 0;
    for (int i = 1; i < start_q.size(); i++) if (start_q[i] - start_q[i-1] != 10) bad++;
    for (int i = 0; i < strobe_q.size(); i++) if (i >= start_q.size() || strobe_q[i] != start_q[i] + 4) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL nominal_spacing: got %0d bad intervals expected 0 (start period 10, strobe +4)", bad);
    end
    checks++;
    if (ADC_value_o !== 8'h64) begin
      errors++;
      $display("FAIL nominal_value: got %h expected 64", ADC_value_o);
    end
    checks++;
    if ({overrun_o, timeoutErr_o} !== 2'b00) begin
      errors++;
      $display("FAIL nominal_flags: got ovr=%b tmo=%b expected 0 0", overrun_o, timeoutErr_o);
    end
  endtask

  task automatic test_overrun;
    int e, bad, first;
    setup(4, 6, 8'h2A, 8'd0, e);
    repeat (30) @(negedge clk);
    first = start_q.size() > 0 ? start_q[0] : -1;
    checks++;
    if (overrun_o !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag: got %b expected 1", overrun_o);
    end
    checks++;
    if (start_q.size() != 4 || strobe_q.size() != 3 || first != e + 5) begin
      errors++;
      $display("FAIL overrun_counts: got starts=%0d strobes=%0d first=%0d expected 4 3 %0d",
               start_q.size(), strobe_q.size(), first, e + 5);
    end
    bad = 0;
    for (int i = 1; i < start_q.size(); i++) if (start_q[i] - start_q[i-1] != 8) bad++;
    checks++;
    if (bad != 0 || bad_seq != 0) begin
      errors++;
      $display("FAIL overrun_sequence: got %0d bad spacings, %0d bad start/strobe pairs expected 0 0", bad, bad_seq);
    end
    checks++;
    if (ADC_value_o !== 8'h2A || timeoutErr_o !== 1'b0) begin
      errors++;
      $display("FAIL overrun_value: got val=%h tmo=%b expected 2a 0", ADC_value_o, timeoutErr_o);
    end
    // clear in cycle e+31, then clear collides with the overrun event in cycle e+32
    @(negedge clk);
    clearErr_i = 1'b1;
    @(negedge clk);
    checks++;
    if (overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got %b expected 0", overrun_o);
    end
    @(negedge clk);
    clearErr_i = 1'b0;
    checks++;
    if (overrun_o !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set_wins: got %b expected 1", overrun_o);
    end
  endtask

  task automatic test_timeout;
    int e;
    setup(100, -1, 8'h00, 8'd0, e);
    repeat (165) @(negedge clk);
    checks++;
    if (timeoutErr_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got %b expected 0 at tick+65", timeoutErr_o);
    end
    @(negedge clk);
    checks++;
    if (timeoutErr_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_rise: got %b expected 1 at tick+66", timeoutErr_o);
    end
    force_cyc = e + 170;
    force_data = 8'hFF;
    repeat (6) @(negedge clk);
    checks++;
    if (ADC_value_o !== 8'h2A || strobe_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_late_done: got val=%h strobes=%0d expected 2a 0", ADC_value_o, strobe_q.size());
    end
    repeat (29) @(negedge clk);
    checks++;
    if (start_q.size() != 2 || start_q[start_q.size()-1] != e + 201) begin
      errors++;
      $display("FAIL timeout_next_start: got starts=%0d expected 2 with last at %0d", start_q.size(), e + 201);
    end
  endtask

  task automatic test_tie_clear;
    int e;
    enable_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({overrun_o, timeoutErr_o} !== 2'b11) begin
      errors++;
      $display("FAIL tie_pre_flags: got ovr=%b tmo=%b expected 1 1", overrun_o, timeoutErr_o);
    end
    clearErr_i = 1'b1;
    @(negedge clk);
    clearErr_i = 1'b0;
    checks++;
    if ({overrun_o, timeoutErr_o} !== 2'b00) begin
      errors++;
      $display("FAIL clear_flags: got ovr=%b tmo=%b expected 0 0", overrun_o, timeoutErr_o);
    end
    setup(100, -1, 8'h00, 8'd0, e);
    force_cyc = e + 165;
    force_data = 8'h5A;
    repeat (166) @(negedge clk);
    checks++;
    if (dataValid_STRB_o !== 1'b1 || ADC_value_o !== 8'h5A) begin
      errors++;
      $display("FAIL tie_capture: got strb=%b val=%h expected 1 5a", dataValid_STRB_o, ADC_value_o);
    end
    @(negedge clk);
    checks++;
    if (timeoutErr_o !== 1'b0) begin
      errors++;
      $display("FAIL tie_no_timeout: got %b expected 0", timeoutErr_o);
    end
  endtask

  task automatic test_min_period;
    int e, bad;
    setup(1, 0, 8'h11, 8'd0, e);
    repeat (12) @(negedge clk);
    bad = 0;
    for (int i = 0; i < start_q.size(); i++) if (start_q[i] != e + 3 + 2 * i) bad++;
    checks++;
    if (start_q.size() != 5 || strobe_q.size() != 5 || bad != 0) begin
      errors++;
      $display("FAIL min_period: got starts=%0d strobes=%0d misplaced=%0d expected 5 5 0",
               start_q.size(), strobe_q.size(), bad);
    end
    checks++;
    if (ADC_value_o !== 8'h11 || overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL min_period_value: got val=%h ovr=%b expected 11 0", ADC_value_o, overrun_o);
    end
  endtask

  task automatic test_pwm;
    int e, bad;
    setup(1000, -1, 8'h00, 8'd3, e);
    repeat (20) @(negedge clk);
    bad = 0;
    for (int i = 1; i < pwm_cyc.size(); i++) if (pwm_cyc[i] - pwm_cyc[i-1] != 4) bad++;
    checks++;
    if (pwm_cyc.size() != 5 || bad != 0) begin
      errors++;
      $display("FAIL pwm_div3: got pulses=%0d bad spacings=%0d expected 5 0", pwm_cyc.size(), bad);
    end
    pwmDivider_i = 8'd0;
    repeat (3) @(negedge clk);
    pwm_cyc.delete();
    repeat (8) @(negedge clk);
    checks++;
    if (pwm_cyc.size() != 8) begin
      errors++;
      $display("FAIL pwm_div0: got %0d high cycles of 8 expected 8", pwm_cyc.size());
    end
    enable_i = 1'b0;
    @(negedge clk);
    checks++;
    if (clk_en_PWM_o !== 1'b0) begin
      errors++;
      $display("FAIL pwm_disable: got %b expected 0", clk_en_PWM_o);
    end
  endtask

  task automatic test_abort_reset;
    int e, r, first;
    setup(10, 5, 8'h33, 8'd0, e);
    repeat (12) @(negedge clk);
    enable_i = 1'b0;
    checks++;
    if (start_q.size() != 1) begin
      errors++;
      $display("FAIL abort_started: got starts=%0d expected 1", start_q.size());
    end
    @(negedge clk);
    checks++;
    if ({adc_if.adcStart_o, dataValid_STRB_o, clk_en_PWM_o} !== 3'b000) begin
      errors++;
      $display("FAIL abort_pulses: got %b expected 000", {adc_if.adcStart_o, dataValid_STRB_o, clk_en_PWM_o});
    end
    repeat (9) @(negedge clk);
    checks++;
    if (strobe_q.size() != 0 || ADC_value_o !== 8'h11) begin
      errors++;
      $display("FAIL abort_done_ignored: got strobes=%0d val=%h expected 0 11", strobe_q.size(), ADC_value_o);
    end
    setup(10, 5, 8'h33, 8'd0, e);
    repeat (11) @(negedge clk);
    checks++;
    if (adc_if.adcStart_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_start: got %b expected 1", adc_if.adcStart_o);
    end
    #1 rstn_i = 1'b0;
    #1;
    checks++;
    if ({adc_if.adcStart_o, ADC_value_o, dataValid_STRB_o, clk_en_PWM_o, overrun_o, timeoutErr_o} !== 13'd0) begin
      errors++;
      $display("FAIL async_reset: got start=%b val=%h strb=%b pwm=%b ovr=%b tmo=%b expected all 0",
               adc_if.adcStart_o, ADC_value_o, dataValid_STRB_o, clk_en_PWM_o, overrun_o, timeoutErr_o);
    end
    repeat (3) @(negedge clk);
    rstn_i = 1'b1;
    r = cyc;
    start_q.delete();
    strobe_q.delete();
    pend = 0;
    repeat (17) @(negedge clk);
    first = start_q.size() > 0 ? start_q[0] : -1;
    checks++;
    if (first != r + 11) begin
      errors++;
      $display("FAIL reenable_first_tick: got start at %0d expected %0d", first, r + 11);
    end
    checks++;
    if (strobe_q.size() != 1 || ADC_value_o !== 8'h33) begin
      errors++;
      $display("FAIL reenable_capture: got strobes=%0d val=%h expected 1 33", strobe_q.size(), ADC_value_o);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_overrun();
    test_timeout();
    test_tie_clear();
    test_min_period();
    test_pwm();
    test_abort_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fan_sample_sched.md
# fan_sample_sched

Sample scheduler and ADC handshake controller for the fan PID loop. It generates the periodic conversion request to the external ADC interface and captures the returned sample. It drives the `ADC_value_i` / `dataValid_STRB_i` / `clk_en_PWM_i` inputs of `FanCTRL`, replacing free-running strobes with a programmable, overrun- and timeout-checked sample schedule.

## Interface
- `ADC_BITWIDTH`, 8: width of ADC sample.
- `PERIOD_BITWIDTH`, 16: width of sample-period counter.
- `PWM_DIV_BITWIDTH`, 8: width of PWM clock-enable divider.
- `TIMEOUT_CYCLES`, 64: maximum clocks from `adcStart_o` to `adcDone_i`; must be ≥ 2.

Ports:
- `clk_i`, in, 1: system clock; all logic on rising edge.
- `rstn_i`, in, 1: reset; asynchronous, active-low.
- `enable_i`, in, 1: scheduler run enable.
- `samplePeriod_i`, in, PERIOD_BITWIDTH: clocks between sample ticks; values < 2 are treated as 2.
- `pwmDivider_i`, in, PWM_DIV_BITWIDTH: `clk_en_PWM_o` period minus 1.
- `adcData_i`, in, ADC_BITWIDTH: converted sample, valid when `adcDone_i` = 1.
- `adcDone_i`, in, 1: one-cycle conversion-complete pulse.
- `clearErr_i`, in, 1: clears the sticky error flags.
- `adcStart_o`, out, 1: one-cycle conversion request.
- `ADC_value_o`, out, ADC_BITWIDTH: last captured sample; goes to `FanCTRL.ADC_value_i`.
- `dataValid_STRB_o`, out, 1: one-cycle pulse when `ADC_value_o` has just been updated.
- `clk_en_PWM_o`, out, 1: PWM clock enable.
- `overrun_o`, out, 1: sticky; a tick arrived while a conversion was pending.
- `timeoutErr_o`, out, 1: sticky; conversion exceeded `TIMEOUT_CYCLES`.

## Operation
- All outputs are registered. Reset value of every output is 0. The FSM resets to IDLE and all counters reset to 0.
- FSM states:
  - IDLE → WAIT_TICK when `enable_i` = 1.
  - WAIT_TICK → CONVERT on tick.
  - CONVERT → WAIT_TICK on `adcDone_i` or on timeout.
  - Any state → IDLE when `enable_i` = 0. The counters clear, pending conversions are abandoned, and `ADC_value_o` holds its value.
- Period counter:
  - Runs in WAIT_TICK and CONVERT and counts 0..P-1.
  - Tick is asserted when count = P-1; the counter then wraps to 0.
  - P = max(`samplePeriod_i`, 2), latched at enable and at each wrap. A mid-period change therefore takes effect on the next period.
- Tick in WAIT_TICK: `adcStart_o` = 1 for exactly one cycle, and the FSM enters CONVERT with the timeout counter at 0.
- Tick in CONVERT: the tick is dropped and `overrun_o` is set. The conversion continues and no second `adcStart_o` is issued.
- CONVERT with `adcDone_i` = 1: `ADC_value_o` ← `adcData_i` and `dataValid_STRB_o` = 1 on the next cycle, and the FSM returns to WAIT_TICK.
- CONVERT timeout: when the timeout counter reaches `TIMEOUT_CYCLES` without `adcDone_i`, `timeoutErr_o` is set and the FSM returns to WAIT_TICK. There is no strobe and `ADC_value_o` holds.
- `adcDone_i` in the same cycle as the timeout: done wins, and the sample is captured with no error.
- `adcDone_i` outside CONVERT, including a late done after a timeout or abort, is ignored.
- `clearErr_i` clears both sticky flags. A set event in the same cycle as `clearErr_i` wins, so the flag stays 1.
- PWM divider:
  - Runs only while `enable_i` = 1.
  - `clk_en_PWM_o` pulses for 1 cycle every `pwmDivider_i`+1 clocks.
  - `pwmDivider_i` = 0 gives a constant 1.
  - The divider is independent of the FSM; its counter clears to 0 when `enable_i` = 0.

## Timing
- Enable asserted in cycle E: the period counter starts at E+1, and the first tick occurs P-1 cycles later.
- Tick in cycle T: `adcStart_o` is high in T+1.
- `adcDone_i` sampled in cycle D: `ADC_value_o` is updated and `dataValid_STRB_o` is high in D+1.
  - The strobe never coincides with `adcStart_o` for the same sample.
- Timeout: if `adcDone_i` never arrives, `timeoutErr_o` is high at T+1+`TIMEOUT_CYCLES`+1.
- Sample rate = f_clk / P, provided conversion latency < P-1.
- `enable_i` deassert: FSM is IDLE and all pulse outputs are 0 from the next cycle.
- `rstn_i` assertion at any time clears all outputs immediately (asynchronous), including during CONVERT.

## Test plan
- Nominal sampling:
  - Stimulus: P = 10; the ADC model returns `adcDone_i` 3 cycles after start, with data 0x64.
  - Required: `adcStart_o` every 10 clocks, `dataValid_STRB_o` 4 cycles after each start, `ADC_value_o` = 0x64, no error flags.
- Overrun:
  - Stimulus: P = 4; done latency 6.
  - Required: `overrun_o` = 1; starts only every 8 clocks; every strobe is preceded by exactly one start.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES` = 64; no `adcDone_i`.
  - Required: `timeoutErr_o` rises 66 cycles after the tick; no strobe; the next tick still issues `adcStart_o`; a late `adcDone_i` with data 0xFF leaves `ADC_value_o` unchanged.
- Tie and clear:
  - Stimulus: `adcDone_i` in the exact timeout cycle, then pulse `clearErr_i`.
  - Required: sample captured with `timeoutErr_o` = 0; `clearErr_i` clears a previously set `overrun_o`.
- PWM divider:
  - Stimulus: `pwmDivider_i` = 3, then `pwmDivider_i` = 0.
  - Required: `clk_en_PWM_o` pulses 1 of every 4 clocks, then stays constant 1; `enable_i` = 0 forces it to 0 next cycle.
- Abort and reset:
  - Stimulus: deassert `enable_i` mid-CONVERT, then assert `rstn_i` low while enabled.
  - Required: no strobe after the abort; the done is ignored; reset zeroes all outputs asynchronously; the first tick after re-enable occurs P-1 cycles after the counter start.
